// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// 1-bit full-adder cell shared across all bit positions of the serial adder.
module fa_module (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell is reused LSB-first, one bit per clock,
// with operands and result exchanged over valid/ready handshakes.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, res;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s, fa_cout;
  logic             last_bit;

  fa_module u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (in_valid)  state_nxt = RUN;
        RUN:     if (last_bit)  state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Datapath: clear only rewinds the counter; res/carry keep the last result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_a  <= '0;
      sh_b  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sh_a  <= op_a;
            sh_b  <= op_b;
            carry <= cin;
            cnt   <= '0;
            res   <= '0;
          end
        end
        RUN: begin
          sh_a  <= sh_a >> 1;
          sh_b  <= sh_b >> 1;
          res   <= {fa_s, res[WIDTH-1:1]};
          carry <= fa_cout;
          cnt   <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = res;
  assign cout      = carry;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: golden a+b+cin results are queued at
// operand acceptance and compared when the DUT presents out_valid.
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
  } result_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, clear, out_valid, out_ready, cin, cout, busy;
  logic [WIDTH-1:0] op_a, op_b, sum;

  result_t exp_q[$];
  int      vectors     = 0;
  int      miscompares = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic result_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic c);
    logic [WIDTH:0] t;
    result_t        r;
    t = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c};
    r.sum  = t[WIDTH-1:0];
    r.cout = t[WIDTH];
    return r;
  endfunction

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    int n = 0;
    while (!in_ready && n < 4 * WIDTH) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'(1));
    op_a     = a;
    op_b     = b;
    cin      = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'(1));
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c,
                        input int bp);
    int      n = 0;
    result_t e;
    start_op(a, b, c);
    exp_q.push_back(model(a, b, c));
    while (!out_valid && n < 4 * WIDTH) begin
      check("in_ready_run", 32'(in_ready), 32'(0));
      tick();
      n++;
    end
    check("latency", 32'(n), 32'(WIDTH));
    e = exp_q.pop_front();
    if (!out_valid) begin
      clear = 1'b1;
      tick();
      clear = 1'b0;
      return;
    end
    // Hold off the consumer while offering fresh operands that must be ignored.
    for (int i = 0; i < bp; i++) begin
      in_valid = 1'b1;
      op_a     = WIDTH'($urandom);
      op_b     = WIDTH'($urandom);
      cin      = 1'($urandom_range(0, 1));
      tick();
      check("bp_out_valid", 32'(out_valid), 32'(1));
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_sum", 32'(sum), 32'(e.sum));
      check("bp_cout", 32'(cout), 32'(e.cout));
    end
    in_valid = 1'b0;
    check("sum", 32'(sum), 32'(e.sum));
    check("cout", 32'(cout), 32'(e.cout));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_out_valid", 32'(out_valid), 32'(0));
    check("post_hs_in_ready", 32'(in_ready), 32'(1));
    check("post_hs_busy", 32'(busy), 32'(0));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    cin       = 1'b0;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_sum", 32'(sum), 32'(0));
    check("rst_cout", 32'(cout), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed sums, including full ripple and carry-in edge cases.
    run_op(8'h5A, 8'h3C, 1'b0, 0);
    check("dir_5a_3c", 32'(sum), 32'h96);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    check("dir_ff_01_cout", 32'(cout), 32'(1));
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    check("dir_ff_ff_1", 32'({cout, sum}), 32'h1FF);
    run_op(8'h00, 8'h00, 1'b1, 0);
    check("dir_00_00_1", 32'({cout, sum}), 32'h001);

    // Backpressure for five cycles with ignored in_valid.
    run_op(8'h5A, 8'h3C, 1'b0, 5);

    // clear beats a simultaneous input handshake.
    in_valid = 1'b1;
    clear    = 1'b1;
    op_a     = 8'h77;
    tick();
    in_valid = 1'b0;
    clear    = 1'b0;
    check("clear_vs_accept", 32'(in_ready), 32'(1));

    // Abort in the 4th RUN cycle.
    start_op(8'h11, 8'h22, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort_no_valid", 32'(out_valid), 32'(0));
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'(1));
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_out_valid", 32'(out_valid), 32'(0));
    run_op(8'h10, 8'h20, 1'b0, 0);
    check("after_abort", 32'(sum), 32'h30);

    // Asynchronous reset mid-RUN, asserted between edges.
    start_op(8'hAB, 8'hCD, 1'b1);
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'(1));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_out_valid", 32'(out_valid), 32'(0));
    check("mid_rst_sum", 32'(sum), 32'(0));
    check("mid_rst_cout", 32'(cout), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 200; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)));
    end

    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
